turn_controller: RTL and testbench
==================================

TURN_CONTROLLER -- requirements
Module: turn_controller

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, as listed in REQ-002 and REQ-003.
REQ-002 clk  in  1  system clock; all state updates occur on the rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 start  in  1  single-cycle pulse that begins a new game; sampled only in IDLE or DONE.
REQ-005 select_valid  in  1  single-cycle strobe; cardselect is valid in this cycle.
REQ-006 cardselect  in  9  one-hot card choice; bit i selects card value i+1.
REQ-007 turn  out  1  player to act: 0 = P1, 1 = P2.
REQ-008 p1_handout_pulse, p2_handout_pulse  out  1 each  one-cycle pulse that commits the card to the player's hand datapath.
REQ-009 p1_used, p2_used  out  9 each  cards each player has already played.
REQ-010 select_error  out  1  one-cycle pulse when a selection is rejected.
REQ-011 round_cnt  out  4  completed rounds, 0..9.
REQ-012 p1_score, p2_score  out  4 each  rounds won, 0..9.
REQ-013 round_result  out  2  last round: 00 none, 01 P1, 10 P2, 11 draw.
REQ-014 game_over  out  1  high in DONE.
REQ-015 winner  out  2  valid when game_over: 01 P1, 10 P2, 11 draw.

Function
REQ-016 The FSM SHALL have the states IDLE, LEAD_SEL, FOLLOW_SEL, COMPARE and DONE.
REQ-017 IDLE/DONE + start SHALL clear used, scores, round_cnt, round_result and winner, set leader=P1, and enter LEAD_SEL.
REQ-018 turn SHALL equal the leader in LEAD_SEL and the non-leader in FOLLOW_SEL; in other states it holds its previous value.
REQ-019 A selection is valid only if cardselect is exactly one-hot and the selected bit is clear in the acting player's used vector.
REQ-020 A valid select_valid in a SEL state SHALL, in the next cycle, pulse the acting player's handout for exactly 1 cycle, set that player's used bit, latch the 4-bit card index, and advance LEAD_SEL->FOLLOW_SEL or FOLLOW_SEL->COMPARE.
REQ-021 An invalid select_valid SHALL pulse select_error in the next cycle and SHALL leave the state, used vectors and handout outputs unchanged.
REQ-022 select_valid outside the SEL states SHALL be ignored with no error; start outside IDLE/DONE SHALL be ignored.
REQ-023 COMPARE SHALL last 1 cycle and SHALL compare the P1 and P2 indices: the higher card scores +1 for its owner and becomes leader; on equal values, round_result=11, no score change and the leader is unchanged; round_cnt SHALL increment by 1.
REQ-024 After COMPARE, the FSM SHALL enter DONE if the new round_cnt==9, else LEAD_SEL.
REQ-025 On entering DONE, winner SHALL be set by score comparison (equal -> 11), game_over SHALL be 1, and the block SHALL hold until start or reset.
REQ-026 Scores and round_cnt SHALL never exceed 9; no wrap-around is possible.

Reset
REQ-027 Reset SHALL force IDLE, all outputs to 0, leader to P1 and the latched indices to 0, immediately and regardless of state, including mid-round.
REQ-028 Reset SHALL discard a pending handout; the first post-reset handout occurs only after start.

Structure
REQ-029 Package card_pkg SHALL hold NUM_CARDS=9, NUM_ROUNDS=9, the state enum, and the result/winner 2-bit codes.
REQ-030 One sub-module, card_index_enc, SHALL convert the 9-bit one-hot vector to a 4-bit index plus an onehot_ok flag.
REQ-031 All outputs SHALL be registered.

Verification
REQ-032 reset, start, P1 selects 9'h004 (val 3), then P2 selects 9'h001 (val 1) -> p1/p2 handout pulses on consecutive accepts; COMPARE gives p1_score=1, round_result=01, leader=P1.
REQ-033 P1 reselects an already used card, or cardselect=9'h003 -> select_error=1 for 1 cycle, no handout, turn unchanged.
REQ-034 Round in which both players play 9'h010 -> round_result=11, scores unchanged, leader unchanged, round_cnt+1.
REQ-035 Full 9-round game with P2 winning 5-4 -> round_cnt=9, game_over=1, winner=10, p1_used=p2_used=9'h1FF.
REQ-036 Assert reset mid-FOLLOW_SEL -> all outputs 0 and state IDLE in the same cycle; select_valid is ignored until start.

Source files
------------

// File: rtl/card_pkg.sv
// Shared constants, state encoding and small helpers for the two-player card game controller.
package card_pkg;

  localparam int NUM_CARDS  = 9;
  localparam int NUM_ROUNDS = 9;
  localparam int IDX_W      = 4;

  localparam logic [IDX_W-1:0] MAX_COUNT = 4'(NUM_ROUNDS);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_LEAD_SEL   = 3'd1,
    S_FOLLOW_SEL = 3'd2,
    S_COMPARE    = 3'd3,
    S_DONE       = 3'd4
  } state_e;

  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_P1   = 2'b01;
  localparam logic [1:0] RES_P2   = 2'b10;
  localparam logic [1:0] RES_DRAW = 2'b11;

  localparam logic PLAYER_P1 = 1'b0;
  localparam logic PLAYER_P2 = 1'b1;

  // Same encoding serves both the per-round result and the final winner.
  function automatic logic [1:0] compare_code(input logic [IDX_W-1:0] a, input logic [IDX_W-1:0] b);
    if (a > b) begin
      return RES_P1;
    end else if (b > a) begin
      return RES_P2;
    end else begin
      return RES_DRAW;
    end
  endfunction

  function automatic logic [IDX_W-1:0] sat_inc(input logic [IDX_W-1:0] v);
    if (v < MAX_COUNT) begin
      return v + 4'd1;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/card_index_enc.sv
// One-hot card vector to binary index (bit i -> index i), with an exact-one-hot flag.
module card_index_enc
  import card_pkg::*;
(
  input  logic [NUM_CARDS-1:0] onehot_i,
  output logic [IDX_W-1:0]     index_o,
  output logic                 onehot_ok_o
);

  logic [IDX_W-1:0] count_s;

  // OR-reduction encode; the index is only meaningful when onehot_ok_o is set.
  always_comb begin
    index_o = '0;
    count_s = '0;
    for (int i = 0; i < NUM_CARDS; i++) begin
      index_o = index_o | (IDX_W'(i) & {IDX_W{onehot_i[i]}});
      count_s = count_s + {3'b000, onehot_i[i]};
    end
    onehot_ok_o = (count_s == 4'd1);
  end

endmodule

// File: rtl/turn_controller.sv
// Turn sequencing, card validation, round scoring and game-end detection for a
// nine-round, two-player high-card game. All outputs come straight from flops.
module turn_controller
  import card_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 select_valid,
  input  logic [NUM_CARDS-1:0] cardselect,
  output logic                 turn,
  output logic                 p1_handout_pulse,
  output logic                 p2_handout_pulse,
  output logic [NUM_CARDS-1:0] p1_used,
  output logic [NUM_CARDS-1:0] p2_used,
  output logic                 select_error,
  output logic [IDX_W-1:0]     round_cnt,
  output logic [IDX_W-1:0]     p1_score,
  output logic [IDX_W-1:0]     p2_score,
  output logic [1:0]           round_result,
  output logic                 game_over,
  output logic [1:0]           winner
);

  state_e               state_q, state_d;
  logic                 leader_q, leader_d;
  logic                 turn_q, turn_d;
  logic                 p1_ho_q, p1_ho_d;
  logic                 p2_ho_q, p2_ho_d;
  logic                 sel_err_q, sel_err_d;
  logic [NUM_CARDS-1:0] p1_used_q, p1_used_d;
  logic [NUM_CARDS-1:0] p2_used_q, p2_used_d;
  logic [IDX_W-1:0]     round_cnt_q, round_cnt_d;
  logic [IDX_W-1:0]     p1_score_q, p1_score_d;
  logic [IDX_W-1:0]     p2_score_q, p2_score_d;
  logic [1:0]           round_result_q, round_result_d;
  logic                 game_over_q, game_over_d;
  logic [1:0]           winner_q, winner_d;
  logic [IDX_W-1:0]     p1_idx_q, p1_idx_d;
  logic [IDX_W-1:0]     p2_idx_q, p2_idx_d;

  logic [IDX_W-1:0]     card_idx_s;
  logic                 onehot_ok_s;
  logic                 actor_s;
  logic [NUM_CARDS-1:0] actor_used_s;
  logic                 sel_ok_s;
  logic [1:0]           cmp_res_s;

  card_index_enc u_enc (
    .onehot_i    (cardselect),
    .index_o     (card_idx_s),
    .onehot_ok_o (onehot_ok_s)
  );

  assign actor_s      = (state_q == S_LEAD_SEL) ? leader_q : ~leader_q;
  assign actor_used_s = (actor_s == PLAYER_P2) ? p2_used_q : p1_used_q;
  assign sel_ok_s     = onehot_ok_s && ((actor_used_s & cardselect) == 9'h000);
  assign cmp_res_s    = compare_code(p1_idx_q, p2_idx_q);

  always_comb begin
    state_d        = state_q;
    leader_d       = leader_q;
    turn_d         = turn_q;
    p1_ho_d        = 1'b0;
    p2_ho_d        = 1'b0;
    sel_err_d      = 1'b0;
    p1_used_d      = p1_used_q;
    p2_used_d      = p2_used_q;
    round_cnt_d    = round_cnt_q;
    p1_score_d     = p1_score_q;
    p2_score_d     = p2_score_q;
    round_result_d = round_result_q;
    game_over_d    = game_over_q;
    winner_d       = winner_q;
    p1_idx_d       = p1_idx_q;
    p2_idx_d       = p2_idx_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d        = S_LEAD_SEL;
          leader_d       = PLAYER_P1;
          turn_d         = PLAYER_P1;
          p1_used_d      = '0;
          p2_used_d      = '0;
          round_cnt_d    = '0;
          p1_score_d     = '0;
          p2_score_d     = '0;
          round_result_d = RES_NONE;
          winner_d       = RES_NONE;
          game_over_d    = 1'b0;
          p1_idx_d       = '0;
          p2_idx_d       = '0;
        end else begin
          state_d = state_q;
        end
      end

      S_LEAD_SEL, S_FOLLOW_SEL: begin
        if (select_valid && sel_ok_s) begin
          if (actor_s == PLAYER_P2) begin
            p2_used_d = p2_used_q | cardselect;
            p2_ho_d   = 1'b1;
            p2_idx_d  = card_idx_s;
          end else begin
            p1_used_d = p1_used_q | cardselect;
            p1_ho_d   = 1'b1;
            p1_idx_d  = card_idx_s;
          end
          if (state_q == S_LEAD_SEL) begin
            state_d = S_FOLLOW_SEL;
            turn_d  = ~leader_q;
          end else begin
            state_d = S_COMPARE;
            turn_d  = turn_q;
          end
        end else if (select_valid) begin
          sel_err_d = 1'b1;
        end else begin
          sel_err_d = 1'b0;
        end
      end

      // Round winner takes the lead; a draw keeps the current leader.
      S_COMPARE: begin
        round_result_d = cmp_res_s;
        case (cmp_res_s)
          RES_P1: begin
            p1_score_d = sat_inc(p1_score_q);
            leader_d   = PLAYER_P1;
          end
          RES_P2: begin
            p2_score_d = sat_inc(p2_score_q);
            leader_d   = PLAYER_P2;
          end
          default: begin
            leader_d = leader_q;
          end
        endcase
        round_cnt_d = sat_inc(round_cnt_q);
        if (round_cnt_d == MAX_COUNT) begin
          state_d     = S_DONE;
          game_over_d = 1'b1;
          winner_d    = compare_code(p1_score_d, p2_score_d);
        end else begin
          state_d = S_LEAD_SEL;
          turn_d  = leader_d;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      leader_q       <= PLAYER_P1;
      turn_q         <= 1'b0;
      p1_ho_q        <= 1'b0;
      p2_ho_q        <= 1'b0;
      sel_err_q      <= 1'b0;
      p1_used_q      <= '0;
      p2_used_q      <= '0;
      round_cnt_q    <= '0;
      p1_score_q     <= '0;
      p2_score_q     <= '0;
      round_result_q <= RES_NONE;
      game_over_q    <= 1'b0;
      winner_q       <= RES_NONE;
      p1_idx_q       <= '0;
      p2_idx_q       <= '0;
    end else begin
      state_q        <= state_d;
      leader_q       <= leader_d;
      turn_q         <= turn_d;
      p1_ho_q        <= p1_ho_d;
      p2_ho_q        <= p2_ho_d;
      sel_err_q      <= sel_err_d;
      p1_used_q      <= p1_used_d;
      p2_used_q      <= p2_used_d;
      round_cnt_q    <= round_cnt_d;
      p1_score_q     <= p1_score_d;
      p2_score_q     <= p2_score_d;
      round_result_q <= round_result_d;
      game_over_q    <= game_over_d;
      winner_q       <= winner_d;
      p1_idx_q       <= p1_idx_d;
      p2_idx_q       <= p2_idx_d;
    end
  end

  assign turn             = turn_q;
  assign p1_handout_pulse = p1_ho_q;
  assign p2_handout_pulse = p2_ho_q;
  assign p1_used          = p1_used_q;
  assign p2_used          = p2_used_q;
  assign select_error     = sel_err_q;
  assign round_cnt        = round_cnt_q;
  assign p1_score         = p1_score_q;
  assign p2_score         = p2_score_q;
  assign round_result     = round_result_q;
  assign game_over        = game_over_q;
  assign winner           = winner_q;

endmodule

// File: tb/tb_turn_controller.sv
// Self-checking bench for turn_controller: directed vector table, mid-round reset,
// and a full nine-round game scored by a behavioural reference model.
module tb_turn_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       select_valid = 1'b0;
  logic [8:0] cardselect = 9'h000;
  logic       turn, p1_handout_pulse, p2_handout_pulse, select_error, game_over;
  logic [8:0] p1_used, p2_used;
  logic [3:0] round_cnt, p1_score, p2_score;
  logic [1:0] round_result, winner;

  turn_controller dut (
    .clk(clk), .reset(reset), .start(start), .select_valid(select_valid),
    .cardselect(cardselect), .turn(turn), .p1_handout_pulse(p1_handout_pulse),
    .p2_handout_pulse(p2_handout_pulse), .p1_used(p1_used), .p2_used(p2_used),
    .select_error(select_error), .round_cnt(round_cnt), .p1_score(p1_score),
    .p2_score(p2_score), .round_result(round_result), .game_over(game_over),
    .winner(winner)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       turn; logic h1; logic h2; logic err;
    logic [8:0] u1;   logic [8:0] u2;
    logic [3:0] rc;   logic [3:0] s1; logic [3:0] s2;
    logic [1:0] rr;   logic go;   logic [1:0] win;
  } exp_t;

  typedef struct {
    logic st; logic sv; logic [8:0] cs; exp_t e;
  } vec_t;

  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];

  function automatic exp_t mk(input logic t, input logic h1, input logic h2, input logic err,
                              input logic [8:0] u1, input logic [8:0] u2, input logic [3:0] rc,
                              input logic [3:0] s1, input logic [3:0] s2, input logic [1:0] rr);
    exp_t e;
    e.turn = t; e.h1 = h1; e.h2 = h2; e.err = err; e.u1 = u1; e.u2 = u2;
    e.rc = rc; e.s1 = s1; e.s2 = s2; e.rr = rr; e.go = 1'b0; e.win = 2'b00;
    return e;
  endfunction

  function automatic vec_t mkv(input logic st, input logic sv, input logic [8:0] cs, input exp_t e);
    vec_t v;
    v.st = st; v.sv = sv; v.cs = cs; v.e = e;
    return v;
  endfunction

  task automatic chk(input string nm, input string f, input logic [8:0] act, input logic [8:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s.%s actual=%h required=%h", nm, f, act, req);
    end
  endtask

  task automatic check_out(input string nm);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s scoreboard empty", nm);
    end else begin
      e = exp_q.pop_front();
      chk(nm, "turn", 9'(turn), 9'(e.turn));
      chk(nm, "p1_handout", 9'(p1_handout_pulse), 9'(e.h1));
      chk(nm, "p2_handout", 9'(p2_handout_pulse), 9'(e.h2));
      chk(nm, "select_error", 9'(select_error), 9'(e.err));
      chk(nm, "p1_used", p1_used, e.u1);
      chk(nm, "p2_used", p2_used, e.u2);
      chk(nm, "round_cnt", 9'(round_cnt), 9'(e.rc));
      chk(nm, "p1_score", 9'(p1_score), 9'(e.s1));
      chk(nm, "p2_score", 9'(p2_score), 9'(e.s2));
      chk(nm, "round_result", 9'(round_result), 9'(e.rr));
      chk(nm, "game_over", 9'(game_over), 9'(e.go));
      chk(nm, "winner", 9'(winner), 9'(e.win));
    end
  endtask

  task automatic drive_cycle(input logic st, input logic sv, input logic [8:0] cs,
                             input exp_t e, input string nm);
    start = st; select_valid = sv; cardselect = cs;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0; select_valid = 1'b0; cardselect = 9'h000;
    check_out(nm);
  endtask

  task automatic apply_reset();
    reset = 1'b1; start = 1'b0; select_valid = 1'b0; cardselect = 9'h000;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Behavioural reference model of the game
  exp_t       m;
  int         m_st;
  logic       m_lead;
  logic [3:0] m_v1, m_v2;

  function automatic logic [3:0] cval(input logic [8:0] cs);
    logic [3:0] v = 4'd0;
    for (int i = 0; i < 9; i++) if (cs[i]) v = 4'(i + 1);
    return v;
  endfunction

  task automatic model_step(input logic st, input logic sv, input logic [8:0] cs, output exp_t e);
    logic       act;
    logic [8:0] used;
    m.h1 = 1'b0; m.h2 = 1'b0; m.err = 1'b0;
    case (m_st)
      0, 4: if (st) begin
        m = mk(1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 9'h000, 4'd0, 4'd0, 4'd0, 2'b00);
        m_lead = 1'b0; m_v1 = 4'd0; m_v2 = 4'd0; m_st = 1;
      end
      1, 2: if (sv) begin
        act  = (m_st == 1) ? m_lead : !m_lead;
        used = act ? m.u2 : m.u1;
        if ($countones(cs) == 1 && (used & cs) == 9'h000) begin
          if (act) begin m.u2 = m.u2 | cs; m.h2 = 1'b1; m_v2 = cval(cs); end
          else     begin m.u1 = m.u1 | cs; m.h1 = 1'b1; m_v1 = cval(cs); end
          if (m_st == 1) begin m_st = 2; m.turn = !m_lead; end
          else m_st = 3;
        end else begin
          m.err = 1'b1;
        end
      end
      3: begin
        if (m_v1 > m_v2)      begin m.s1 = m.s1 + 4'd1; m.rr = 2'b01; m_lead = 1'b0; end
        else if (m_v2 > m_v1) begin m.s2 = m.s2 + 4'd1; m.rr = 2'b10; m_lead = 1'b1; end
        else m.rr = 2'b11;
        m.rc = m.rc + 4'd1;
        if (m.rc == 4'd9) begin
          m_st = 4; m.go = 1'b1;
          m.win = (m.s1 > m.s2) ? 2'b01 : (m.s2 > m.s1) ? 2'b10 : 2'b11;
        end else begin
          m_st = 1; m.turn = m_lead;
        end
      end
      default: ;
    endcase
    e = m;
  endtask

  vec_t tbl[22];
  exp_t z;
  exp_t e;
  int   p1c[9] = '{9, 8, 7, 6, 1, 2, 3, 4, 5};
  int   p2c[9] = '{1, 2, 3, 4, 5, 6, 7, 8, 9};

  initial begin
    z = mk(1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 9'h000, 4'd0, 4'd0, 4'd0, 2'b00);
    //               st    sv    card    turn  h1    h2    err   u1      u2      rc    s1    s2    rr
    tbl[0]  = mkv(1'b0, 1'b1, 9'h001, z);
    tbl[1]  = mkv(1'b1, 1'b0, 9'h000, mk(1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 9'h000, 4'd0, 4'd0, 4'd0, 2'b00));
    tbl[2]  = mkv(1'b0, 1'b1, 9'h004, mk(1'b1, 1'b1, 1'b0, 1'b0, 9'h004, 9'h000, 4'd0, 4'd0, 4'd0, 2'b00));
    tbl[3]  = mkv(1'b0, 1'b1, 9'h001, mk(1'b1, 1'b0, 1'b1, 1'b0, 9'h004, 9'h001, 4'd0, 4'd0, 4'd0, 2'b00));
    tbl[4]  = mkv(1'b0, 1'b0, 9'h000, mk(1'b0, 1'b0, 1'b0, 1'b0, 9'h004, 9'h001, 4'd1, 4'd1, 4'd0, 2'b01));
    tbl[5]  = mkv(1'b0, 1'b1, 9'h004, mk(1'b0, 1'b0, 1'b0, 1'b1, 9'h004, 9'h001, 4'd1, 4'd1, 4'd0, 2'b01));
    tbl[6]  = mkv(1'b0, 1'b1, 9'h003, mk(1'b0, 1'b0, 1'b0, 1'b1, 9'h004, 9'h001, 4'd1, 4'd1, 4'd0, 2'b01));
    tbl[7]  = mkv(1'b0, 1'b0, 9'h000, mk(1'b0, 1'b0, 1'b0, 1'b0, 9'h004, 9'h001, 4'd1, 4'd1, 4'd0, 2'b01));
    tbl[8]  = mkv(1'b1, 1'b0, 9'h000, mk(1'b0, 1'b0, 1'b0, 1'b0, 9'h004, 9'h001, 4'd1, 4'd1, 4'd0, 2'b01));
    tbl[9]  = mkv(1'b0, 1'b1, 9'h010, mk(1'b1, 1'b1, 1'b0, 1'b0, 9'h014, 9'h001, 4'd1, 4'd1, 4'd0, 2'b01));
    tbl[10] = mkv(1'b0, 1'b1, 9'h003, mk(1'b1, 1'b0, 1'b0, 1'b1, 9'h014, 9'h001, 4'd1, 4'd1, 4'd0, 2'b01));
    tbl[11] = mkv(1'b0, 1'b1, 9'h010, mk(1'b1, 1'b0, 1'b1, 1'b0, 9'h014, 9'h011, 4'd1, 4'd1, 4'd0, 2'b01));
    tbl[12] = mkv(1'b0, 1'b0, 9'h000, mk(1'b0, 1'b0, 1'b0, 1'b0, 9'h014, 9'h011, 4'd2, 4'd1, 4'd0, 2'b11));
    tbl[13] = mkv(1'b0, 1'b1, 9'h001, mk(1'b1, 1'b1, 1'b0, 1'b0, 9'h015, 9'h011, 4'd2, 4'd1, 4'd0, 2'b11));
    tbl[14] = mkv(1'b0, 1'b1, 9'h100, mk(1'b1, 1'b0, 1'b1, 1'b0, 9'h015, 9'h111, 4'd2, 4'd1, 4'd0, 2'b11));
    tbl[15] = mkv(1'b0, 1'b0, 9'h000, mk(1'b1, 1'b0, 1'b0, 1'b0, 9'h015, 9'h111, 4'd3, 4'd1, 4'd1, 2'b10));
    tbl[16] = mkv(1'b0, 1'b1, 9'h001, mk(1'b1, 1'b0, 1'b0, 1'b1, 9'h015, 9'h111, 4'd3, 4'd1, 4'd1, 2'b10));
    tbl[17] = mkv(1'b0, 1'b1, 9'h002, mk(1'b0, 1'b0, 1'b1, 1'b0, 9'h015, 9'h113, 4'd3, 4'd1, 4'd1, 2'b10));
    tbl[18] = mkv(1'b0, 1'b1, 9'h002, mk(1'b0, 1'b1, 1'b0, 1'b0, 9'h017, 9'h113, 4'd3, 4'd1, 4'd1, 2'b10));
    tbl[19] = mkv(1'b0, 1'b0, 9'h000, mk(1'b1, 1'b0, 1'b0, 1'b0, 9'h017, 9'h113, 4'd4, 4'd1, 4'd1, 2'b11));
    tbl[20] = mkv(1'b0, 1'b1, 9'h000, mk(1'b1, 1'b0, 1'b0, 1'b1, 9'h017, 9'h113, 4'd4, 4'd1, 4'd1, 2'b11));
    tbl[21] = mkv(1'b0, 1'b1, 9'h1FF, mk(1'b1, 1'b0, 1'b0, 1'b1, 9'h017, 9'h113, 4'd4, 4'd1, 4'd1, 2'b11));

    apply_reset();
    exp_q.push_back(z);
    check_out("reset_state");

    for (int i = 0; i < 22; i++) begin
      drive_cycle(tbl[i].st, tbl[i].sv, tbl[i].cs, tbl[i].e, $sformatf("vec%0d", i));
    end

    // Reset while P1's handout pulse is high and the round is in FOLLOW_SEL
    apply_reset();
    drive_cycle(1'b1, 1'b0, 9'h000, z, "rst_start");
    drive_cycle(1'b0, 1'b1, 9'h008, mk(1'b1, 1'b1, 1'b0, 1'b0, 9'h008, 9'h000, 4'd0, 4'd0, 4'd0, 2'b00), "rst_p1sel");
    #2 reset = 1'b1;
    #1;
    exp_q.push_back(z);
    check_out("rst_async");
    @(posedge clk);
    #1 reset = 1'b0;
    drive_cycle(1'b0, 1'b1, 9'h008, z, "rst_ignore_a");
    drive_cycle(1'b0, 1'b1, 9'h020, z, "rst_ignore_b");
    drive_cycle(1'b1, 1'b0, 9'h000, z, "rst_restart");
    drive_cycle(1'b0, 1'b1, 9'h008, mk(1'b1, 1'b1, 1'b0, 1'b0, 9'h008, 9'h000, 4'd0, 4'd0, 4'd0, 2'b00), "rst_first_ho");

    // Full game, P2 wins 5-4
    apply_reset();
    m = z; m_st = 0; m_lead = 1'b0; m_v1 = 4'd0; m_v2 = 4'd0;
    model_step(1'b1, 1'b0, 9'h000, e);
    drive_cycle(1'b1, 1'b0, 9'h000, e, "game_start");
    for (int r = 0; r < 9; r++) begin
      logic [8:0] c1, c2;
      c1 = 9'h001 << (p1c[r] - 1);
      c2 = 9'h001 << (p2c[r] - 1);
      if (m_lead) begin
        model_step(1'b0, 1'b1, c2, e); drive_cycle(1'b0, 1'b1, c2, e, $sformatf("g%0d_lead", r));
        model_step(1'b0, 1'b1, c1, e); drive_cycle(1'b0, 1'b1, c1, e, $sformatf("g%0d_follow", r));
      end else begin
        model_step(1'b0, 1'b1, c1, e); drive_cycle(1'b0, 1'b1, c1, e, $sformatf("g%0d_lead", r));
        model_step(1'b0, 1'b1, c2, e); drive_cycle(1'b0, 1'b1, c2, e, $sformatf("g%0d_follow", r));
      end
      model_step(1'b0, 1'b0, 9'h000, e);
      drive_cycle(1'b0, 1'b0, 9'h000, e, $sformatf("g%0d_cmp", r));
    end
    chk("game_end", "round_cnt", 9'(round_cnt), 9'd9);
    chk("game_end", "game_over", 9'(game_over), 9'd1);
    chk("game_end", "winner", 9'(winner), 9'd2);
    chk("game_end", "p1_score", 9'(p1_score), 9'd4);
    chk("game_end", "p2_score", 9'(p2_score), 9'd5);
    chk("game_end", "p1_used", p1_used, 9'h1FF);
    chk("game_end", "p2_used", p2_used, 9'h1FF);

    model_step(1'b0, 1'b1, 9'h001, e);
    drive_cycle(1'b0, 1'b1, 9'h001, e, "done_hold");
    model_step(1'b1, 1'b0, 9'h000, e);
    drive_cycle(1'b1, 1'b0, 9'h000, e, "done_restart");
    chk("done_restart", "game_over_cleared", 9'(game_over), 9'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
